// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Load/store initiator for a big-endian byte-array data memory,
//            with sub-word read-modify-write and range fault detection.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wenable,
    output logic        mem_renable,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] c_max_addr = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [15:0] r_wdata;

    logic        r_resp_valid, w_resp_valid_nxt;
    logic        r_resp_err,   w_resp_err_nxt;
    logic [31:0] r_resp_rdata, w_resp_rdata_nxt;
    logic [31:0] r_mem_addr,   w_mem_addr_nxt;
    logic [31:0] r_mem_wdata,  w_mem_wdata_nxt;
    logic        r_mem_wen,    w_mem_wen_nxt;
    logic        r_mem_ren,    w_mem_ren_nxt;

    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_extract;
    logic [31:0] w_merge;

    assign req_ready   = (r_state == ST_IDLE);
    assign w_accept    = req_valid & req_ready;
    // Any address past MEM_BYTES-4 would touch bytes beyond the array; no wrap.
    assign w_fault     = (req_addr > c_max_addr) | (req_size == 2'b11);

    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_rdata  = r_resp_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wenable = r_mem_wen;
    assign mem_renable = r_mem_ren;

    always_comb begin
        w_extract = mem_rdata;
        case (r_size)
            2'b00:   w_extract = r_signed ? {{24{mem_rdata[31]}}, mem_rdata[31:24]}
                                          : {24'h0, mem_rdata[31:24]};
            2'b01:   w_extract = r_signed ? {{16{mem_rdata[31]}}, mem_rdata[31:16]}
                                          : {16'h0, mem_rdata[31:16]};
            default: w_extract = mem_rdata;
        endcase
    end

    // Bytes following the target are written back with their current contents.
    assign w_merge = (r_size == 2'b00) ? {r_wdata[7:0], mem_rdata[23:0]}
                                       : {r_wdata[15:0], mem_rdata[15:0]};

    always_comb begin
        w_state_nxt      = r_state;
        w_resp_valid_nxt = 1'b0;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = 32'h0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_wen_nxt    = 1'b0;
        w_mem_ren_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                    end else if (req_we && (req_size == 2'b10)) begin
                        w_mem_addr_nxt  = req_addr;
                        w_mem_wdata_nxt = req_wdata;
                        w_mem_wen_nxt   = 1'b1;
                        w_state_nxt     = ST_WRITE;
                    end else begin
                        w_mem_addr_nxt = req_addr;
                        w_mem_ren_nxt  = 1'b1;
                        w_state_nxt    = ST_READ;
                    end
                end
            end
            ST_READ: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_we) begin
                    w_mem_wdata_nxt = w_merge;
                    w_mem_wen_nxt   = 1'b1;
                    w_state_nxt     = ST_WRITE;
                end else begin
                    w_resp_rdata_nxt = w_extract;
                    w_resp_valid_nxt = 1'b1;
                    w_state_nxt      = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_resp_valid_nxt = 1'b1;
                w_state_nxt      = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_wen    <= 1'b0;
            r_mem_ren    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_wen    <= w_mem_wen_nxt;
            r_mem_ren    <= w_mem_ren_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_wdata  <= 16'h0;
        end else if (w_accept) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_wdata  <= req_wdata[15:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Scoreboard bench for mem_access_unit paired with a byte memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_wenable, mem_renable;

    mem_access_unit #(.MEM_BYTES(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wenable(mem_wenable), .mem_renable(mem_renable), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: registered read, byte k*4+3 of the reset image holds k.
    logic [7:0] mem [0:63];
    logic       mem_load;
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= (i < 32 && (i % 4) == 3) ? 8'(i / 4) : 8'h00;
        end else begin
            if (mem_wenable)
                for (int i = 0; i < 4; i++)
                    mem[(int'(mem_addr[5:0]) + i) % 64] <= mem_wdata[31 - 8*i -: 8];
            if (mem_renable)
                mem_rdata <= {mem[(int'(mem_addr[5:0]) + 0) % 64], mem[(int'(mem_addr[5:0]) + 1) % 64],
                              mem[(int'(mem_addr[5:0]) + 2) % 64], mem[(int'(mem_addr[5:0]) + 3) % 64]};
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int tests = 0, fails = 0;
    int both_hits = 0, long_hits = 0, fault_hits = 0;
    logic fault_win = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor and strobe invariants, sampled on the falling edge.
    initial begin
        logic prev_wen, prev_ren;
        exp_t e;
        prev_wen = 1'b0;
        prev_ren = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_wenable && mem_renable) both_hits++;
            if ((mem_wenable && prev_wen) || (mem_renable && prev_ren)) long_hits++;
            if (fault_win && (mem_wenable || mem_renable)) fault_hits++;
            prev_wen = mem_wenable;
            prev_ren = mem_renable;
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got err=%b rdata=%h expected no response", resp_err, resp_rdata);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_err"}, 32'(resp_err), 32'(e.err));
                    chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                    chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input string name, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic eerr, input logic [31:0] erdata, input int elat, input bit push);
        int n = 0;
        @(negedge clk);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: got req_ready=0 expected 1 within 50 cycles", name);
            req_valid = 1'b0;
            return;
        end
        if (push) sb.push_back('{name: name, err: eerr, rdata: erdata, lat: elat, acc: cyc + 1});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = ~we; req_size = 2'b11; req_signed = ~sgn; req_addr = 32'hFFFF_FFF0; req_wdata = 32'hA5A5_A5A5;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: got %0d pending responses expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_load = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_strobes", {30'h0, mem_wenable, mem_renable}, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        mem_load = 1'b0;
        rst = 1'b0;

        issue("ld_w8",      1'b0, 2'b10, 1'b0, 32'd8,  32'h0, 1'b0, 32'h0000_0002, 2, 1'b1);
        issue("st_w12",     1'b1, 2'b10, 1'b0, 32'd12, 32'hDEAD_BEEF, 1'b0, 32'h0, 1, 1'b1);
        issue("ld_w12",     1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b1);
        issue("st_b15",     1'b1, 2'b00, 1'b0, 32'd15, 32'hAAAA_AA80, 1'b0, 32'h0, 3, 1'b1);
        issue("ld_w12b",    1'b0, 2'b10, 1'b0, 32'd12, 32'h0, 1'b0, 32'hDEAD_BE80, 2, 1'b1);
        issue("ld_w16",     1'b0, 2'b10, 1'b0, 32'd16, 32'h0, 1'b0, 32'h0000_0004, 2, 1'b1);
        issue("ld_bs15",    1'b0, 2'b00, 1'b1, 32'd15, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 1'b1);
        issue("ld_bu15",    1'b0, 2'b00, 1'b0, 32'd15, 32'h0, 1'b0, 32'h0000_0080, 2, 1'b1);
        issue("st_h20",     1'b1, 2'b01, 1'b0, 32'd20, 32'h5555_1234, 1'b0, 32'h0, 3, 1'b1);
        issue("ld_w20",     1'b0, 2'b10, 1'b0, 32'd20, 32'h0, 1'b0, 32'h1234_0005, 2, 1'b1);
        issue("ld_hs20",    1'b0, 2'b01, 1'b1, 32'd20, 32'h0, 1'b0, 32'h0000_1234, 2, 1'b1);
        issue("ld_hs12",    1'b0, 2'b01, 1'b1, 32'd12, 32'h0, 1'b0, 32'hFFFF_DEAD, 2, 1'b1);
        issue("ld_hu12",    1'b0, 2'b01, 1'b0, 32'd12, 32'h0, 1'b0, 32'h0000_DEAD, 2, 1'b1);
        issue("ld_w60",     1'b0, 2'b10, 1'b0, 32'd60, 32'h0, 1'b0, 32'h0000_0000, 2, 1'b1);
        drain("functional");

        fault_win = 1'b1;
        issue("flt_ld61",   1'b0, 2'b10, 1'b0, 32'd61, 32'h0, 1'b1, 32'h0, 0, 1'b1);
        issue("flt_sz11",   1'b0, 2'b11, 1'b0, 32'd0,  32'h0, 1'b1, 32'h0, 0, 1'b1);
        issue("flt_st61",   1'b1, 2'b10, 1'b0, 32'd61, 32'h1111_1111, 1'b1, 32'h0, 0, 1'b1);
        issue("flt_stsz11", 1'b1, 2'b11, 1'b0, 32'd4,  32'h2222_2222, 1'b1, 32'h0, 0, 1'b1);
        issue("flt_ffff",   1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 0, 1'b1);
        drain("faults");
        @(negedge clk);
        fault_win = 1'b0;
        chk("fault_strobes", 32'(fault_hits), 32'h0);
        issue("ld_w4_pre",  1'b0, 2'b10, 1'b0, 32'd4,  32'h0, 1'b0, 32'h0000_0001, 2, 1'b1);
        drain("post_fault");

        // Reset with the read strobe high: it must drop without a clock edge.
        issue("rst_ld", 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 1'b0, 32'h0, 0, 1'b0);
        chk("pre_rst_ren", 32'(mem_renable), 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_ren", 32'(mem_renable), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset during the read-back phase of a byte store: write must not happen.
        issue("rst_stb4", 1'b1, 2'b00, 1'b0, 32'd4, 32'h0000_0055, 1'b0, 32'h0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_wait_strobes", {30'h0, mem_wenable, mem_renable}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_wen", 32'(mem_wenable), 32'h0);
        chk("rst_hold_valid", 32'(resp_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        issue("ld_w4_post", 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 1'b0, 32'h0000_0001, 2, 1'b1);
        issue("ld_bu7",     1'b0, 2'b00, 1'b0, 32'd7, 32'h0, 1'b0, 32'h0000_0001, 2, 1'b1);
        drain("post_rst");

        repeat (3) @(negedge clk);
        chk("strobe_overlap", 32'(both_hits), 32'h0);
        chk("strobe_length", 32'(long_hits), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
